// File: rtl/hazard_stall_unit_if.sv
// Pipeline hazard signal bundle between the ID/EX pipeline and hazard_stall_unit.
// master = pipeline side (drives hazard sources), slave = hazard unit.
interface hazard_stall_unit_if;
  logic [4:0]  rsID;
  logic [4:0]  rtID;
  logic [4:0]  rtEX;
  logic        memReadEX;
  logic        multiStartEX;
  logic        branchTakenID;
  logic        pcWrite;
  logic        ifIdWrite;
  logic        idExWrite;
  logic        idExBubble;
  logic        exMemBubble;
  logic        ifIdFlush;
  logic [1:0]  state;
  logic [15:0] stallCount;

  modport master (
    output rsID, rtID, rtEX, memReadEX, multiStartEX, branchTakenID,
    input  pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble, ifIdFlush,
    input  state, stallCount
  );

  modport slave (
    input  rsID, rtID, rtEX, memReadEX, multiStartEX, branchTakenID,
    output pcWrite, ifIdWrite, idExWrite, idExBubble, exMemBubble, ifIdFlush,
    output state, stallCount
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use and multi-cycle multiply/divide stall control with branch flush.
// Define HAZARD_STATS_EN to enable the saturating stalled-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MULTI_LATENCY = 4
) (
  input  logic               clock,
  input  logic               reset,
  hazard_stall_unit_if.slave bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MULTI_BUSY = 2'd1,
    MULTI_DONE = 2'd2,
    ILLEGAL    = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(MULTI_LATENCY - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_hazard;
  logic       multi_stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // multiStartEX is only honoured from RUN; BUSY/DONE see it still held by the advancing op
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (bus.multiStartEX) begin
          state_d = MULTI_BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      MULTI_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = MULTI_DONE;
      end
      MULTI_DONE: state_d = RUN;
      default:    state_d = RUN;
    endcase
  end

  assign load_hazard = bus.memReadEX && (bus.rtEX != '0) &&
                       ((bus.rtEX == bus.rsID) || (bus.rtEX == bus.rtID));
  assign multi_stall = ((state_q == RUN) && bus.multiStartEX) || (state_q == MULTI_BUSY);

  always_comb begin
    bus.pcWrite     = 1'b1;
    bus.ifIdWrite   = 1'b1;
    bus.idExWrite   = 1'b1;
    bus.idExBubble  = 1'b0;
    bus.exMemBubble = 1'b0;
    bus.ifIdFlush   = 1'b0;
    if (reset) begin
      if (multi_stall) begin
        bus.pcWrite     = 1'b0;
        bus.ifIdWrite   = 1'b0;
        bus.idExWrite   = 1'b0;
        bus.exMemBubble = 1'b1;
      end else if (load_hazard) begin
        bus.pcWrite    = 1'b0;
        bus.ifIdWrite  = 1'b0;
        bus.idExBubble = 1'b1;
      end else if (bus.branchTakenID) begin
        bus.ifIdFlush = 1'b1;
      end
    end
  end

  assign bus.state = state_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.pcWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stallCount = stall_cnt_q;
`else
  assign bus.stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (MULTI_LATENCY = 4).
module tb_hazard_stall_unit;

  localparam logic [5:0] C_DEF    = 6'b111000;
  localparam logic [5:0] C_LOAD   = 6'b001100;
  localparam logic [5:0] C_MULTI  = 6'b000010;
  localparam logic [5:0] C_BRANCH = 6'b111001;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  hazard_stall_unit_if bus ();

  hazard_stall_unit #(.MULTI_LATENCY(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [5:0] ctrl;
  assign ctrl = {bus.pcWrite, bus.ifIdWrite, bus.idExWrite,
                 bus.idExBubble, bus.exMemBubble, bus.ifIdFlush};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rtex,
                       input logic memrd, input logic multi, input logic br);
    bus.rsID          = rs;
    bus.rtID          = rt;
    bus.rtEX          = rtex;
    bus.memReadEX     = memrd;
    bus.multiStartEX  = multi;
    bus.branchTakenID = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset with every hazard source active: outputs must stay at defaults
    reset = 1'b0;
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1);
    check("reset_ctrl", 16'(ctrl), 16'(C_DEF));
    tick();
    tick();
    check("reset_state", 16'(bus.state), 16'd0);
    check("reset_stallcnt", bus.stallCount, 16'd0);

    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("idle_ctrl", 16'(ctrl), 16'(C_DEF));

    // Load-use on rs, then cleared next cycle
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    check("load_rs_ctrl", 16'(ctrl), 16'(C_LOAD));
    tick();
    check("load_rs_state", 16'(bus.state), 16'd0);
    drive(5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    check("load_after_ctrl", 16'(ctrl), 16'(C_DEF));

    drive(5'd1, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
    check("load_rt_ctrl", 16'(ctrl), 16'(C_LOAD));
    drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("load_r0_ctrl", 16'(ctrl), 16'(C_DEF));
    drive(5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0);
    check("load_nomatch_ctrl", 16'(ctrl), 16'(C_DEF));
    drive(5'd6, 5'd7, 5'd6, 1'b0, 1'b0, 1'b0);
    check("match_noload_ctrl", 16'(ctrl), 16'(C_DEF));

    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("branch_ctrl", 16'(ctrl), 16'(C_BRANCH));
    drive(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
    check("load_over_branch_ctrl", 16'(ctrl), 16'(C_LOAD));
    tick();

    // Multi-cycle op held 4 cycles, coincident load hazard and pending branch
    drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1);
    check("multi0_state", 16'(bus.state), 16'd0);
    check("multi0_ctrl", 16'(ctrl), 16'(C_MULTI));
    tick();
    drive(5'd4, 5'd0, 5'd4, 1'b0, 1'b1, 1'b1);
    check("multi1_state", 16'(bus.state), 16'd1);
    check("multi1_ctrl", 16'(ctrl), 16'(C_MULTI));
    tick();
    check("multi2_state", 16'(bus.state), 16'd1);
    check("multi2_ctrl", 16'(ctrl), 16'(C_MULTI));
    tick();
    check("multi3_state", 16'(bus.state), 16'd2);
    check("multi3_ctrl", 16'(ctrl), 16'(C_BRANCH));
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("multi4_state", 16'(bus.state), 16'd0);
    check("multi4_ctrl", 16'(ctrl), 16'(C_DEF));

    // Reset asserted in the second MULTI_BUSY cycle
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    check("rstmid_pre_state", 16'(bus.state), 16'd1);
    reset = 1'b0;
    #1;
    check("rstmid_ctrl", 16'(ctrl), 16'(C_DEF));
    tick();
    check("rstmid_state", 16'(bus.state), 16'd0);
    check("rstmid_stallcnt", bus.stallCount, 16'd0);
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("rstmid_after_ctrl", 16'(ctrl), 16'(C_DEF));
    check("rstmid_after_state", 16'(bus.state), 16'd0);

    // Stall statistics under a sustained load-use stall
    drive(5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) tick();
`ifdef HAZARD_STATS_EN
    check("stats_3", bus.stallCount, 16'd3);
    for (int unsigned i = 0; i < 69997; i++) tick();
    check("stats_sat", bus.stallCount, 16'hFFFF);
    tick();
    tick();
    check("stats_hold", bus.stallCount, 16'hFFFF);
`else
    check("stats_off_3", bus.stallCount, 16'd0);
    for (int unsigned i = 0; i < 100; i++) tick();
    check("stats_off_100", bus.stallCount, 16'd0);
`endif
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("final_ctrl", 16'(ctrl), 16'(C_DEF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
